// File: rtl/frame_fetch_ctrl_if.sv
// Output stream of frame_fetch_ctrl: valid/ready words tagged
// with start-of-frame and end-of-frame markers.
interface frame_fetch_ctrl_if #(
  parameter int DW = 32
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eof;

  modport master (
    output out_valid, out_data, out_sof, out_eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_sof, out_eof,
    output out_ready
  );
endinterface

// File: rtl/frame_fetch_ctrl.sv
// Drains one FRAME_LEN-word frame from the FIFO read port into a stream.
// Optional sticky underrun flag: define FRAME_FETCH_UNDERRUN_EN.
module frame_fetch_ctrl #(
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int FRAME_LEN      = 80
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      enable,
  output logic                      fifo_rd_en,
  input  logic [RAM_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                      fifo_empty,
  input  logic                      fifo_full,
  input  logic [RAM_ADDR_WIDTH-1:0] fifo_count,
  frame_fetch_ctrl_if.master        out,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      underrun_err,
  input  logic                      err_clr
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] FLEN = CW'(FRAME_LEN);
  localparam logic [RAM_ADDR_WIDTH-1:0] THR =
    RAM_ADDR_WIDTH'(FRAME_LEN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] rd_issued_q, rd_issued_d;
  logic [CW-1:0] wr_sent_q, wr_sent_d;
  logic          inflight_q, inflight_d;
  logic          head_q, head_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [RAM_DATA_WIDTH-1:0] buf_q [2];
  logic [RAM_DATA_WIDTH-1:0] buf_d [2];

  logic       frame_avail;
  logic       xfer;
  logic       pop;
  logic [1:0] occ;

  assign frame_avail = fifo_full | (fifo_count >= THR);
  assign xfer = out.out_valid & out.out_ready;

  // Slots committed after this cycle's transfer leaves the buffer
  assign occ = cnt_q + {1'b0, inflight_q} - {1'b0, xfer};
  assign pop = (state_q == BURST) & (occ < 2'd2) & ~fifo_empty;

  assign fifo_rd_en    = pop;
  assign out.out_valid = (cnt_q != 2'd0);
  assign out.out_data  = buf_q[head_q];
  assign out.out_sof   = out.out_valid & (wr_sent_q == '0);
  assign out.out_eof   = out.out_valid & (wr_sent_q == LAST);
  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    rd_issued_d = rd_issued_q;
    wr_sent_d   = wr_sent_q;
    inflight_d  = pop;
    head_d      = head_q ^ xfer;
    cnt_d       = cnt_q + {1'b0, inflight_q} - {1'b0, xfer};
    buf_d       = buf_q;
    if (inflight_q) buf_d[head_q ^ cnt_q[0]] = fifo_rd_data;
    if (pop)  rd_issued_d = rd_issued_q + 1'b1;
    if (xfer) wr_sent_d   = wr_sent_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (enable & frame_avail) begin
          state_d     = BURST;
          rd_issued_d = '0;
          wr_sent_d   = '0;
        end
      end
      BURST: if (pop && rd_issued_q == LAST) state_d = DRAIN;
      DRAIN: if (wr_sent_q == FLEN) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      rd_issued_q <= '0;
      wr_sent_q   <= '0;
      inflight_q  <= 1'b0;
      head_q      <= 1'b0;
      cnt_q       <= 2'd0;
      buf_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      rd_issued_q <= rd_issued_d;
      wr_sent_q   <= wr_sent_d;
      inflight_q  <= inflight_d;
      head_q      <= head_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
    end
  end

`ifdef FRAME_FETCH_UNDERRUN_EN
  logic err_q, err_d;
  logic ur_set;

  assign ur_set = (state_q == BURST) &
                  (rd_issued_q < FLEN) & fifo_empty;

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (ur_set)  err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign underrun_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign underrun_err   = 1'b0;
`endif

endmodule

// File: tb/tb_frame_fetch_ctrl.sv
// Self-checking bench for frame_fetch_ctrl: FIFO model plus
// scoreboard of expected {sof, eof, data} per streamed word.
module tb_frame_fetch_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int FL = 80;
`ifdef FRAME_FETCH_UNDERRUN_EN
  localparam logic EXP_UR = 1'b1;
`else
  localparam logic EXP_UR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst, enable, err_clr;
  logic          fifo_rd_en, fifo_empty, fifo_full;
  logic [DW-1:0] fifo_rd_data;
  logic [AW-1:0] fifo_count;
  logic          busy, frame_done, underrun_err;

  frame_fetch_ctrl_if #(.DW(DW)) ffi ();

  frame_fetch_ctrl #(
    .RAM_ADDR_WIDTH(AW),
    .RAM_DATA_WIDTH(DW),
    .FRAME_LEN     (FL)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .enable      (enable),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .out         (ffi),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun_err(underrun_err),
    .err_clr     (err_clr)
  );

  logic [DW-1:0] fq [$];
  logic [33:0]   sb [$];
  logic [33:0]   exp_w;
  int  pushcnt;
  logic force_empty, full_mode;

  logic s_valid, s_rd, s_busy, s_fd, s_err, s_xfer;
  logic [33:0] s_obs;
  int cyc, npops, ntx;
  int n_vec, n_err;

  task automatic fifo_upd();
    fifo_empty = force_empty | (fq.size() == 0);
    fifo_full  = full_mode;
    fifo_count = full_mode ? '0 : AW'(fq.size());
  endtask

  task automatic push_words(int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fq.push_back(w);
      sb.push_back({(pushcnt % FL) == 0,
                    (pushcnt % FL) == FL - 1, w});
      pushcnt++;
    end
    fifo_upd();
  endtask

  task automatic flush();
    fq.delete();
    sb.delete();
    pushcnt = 0;
    fifo_upd();
  endtask

  task automatic tick();
    logic p;
    @(negedge clk);
    s_valid = ffi.out_valid;
    s_rd    = fifo_rd_en;
    s_busy  = busy;
    s_fd    = frame_done;
    s_err   = underrun_err;
    s_xfer  = ffi.out_valid & ffi.out_ready;
    s_obs   = {ffi.out_sof, ffi.out_eof, ffi.out_data};
    p       = fifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (p) npops++;
    if (p && fq.size() > 0) fifo_rd_data = fq.pop_front();
    if (s_xfer) ntx++;
    fifo_upd();
  endtask

  task automatic test_reset();
    srst = 1'b1; enable = 1'b0; err_clr = 1'b0;
    ffi.out_ready = 1'b1;
    force_empty = 1'b0; full_mode = 1'b0;
    fifo_rd_data = '0;
    flush();
    @(posedge clk);
    #1;
    tick();
    tick();
    n_vec++;
    if ({s_valid, s_rd, s_busy, s_fd, s_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outs actual=%b required=00000",
               {s_valid, s_rd, s_busy, s_fd, s_err});
    end
    n_vec++;
    if (s_obs !== 34'h0) begin
      n_err++;
      $display("FAIL reset_data actual=%h required=0", s_obs);
    end
    srst = 1'b0;
    tick();
    n_vec++;
    if (s_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy actual=%b required=0", s_busy);
    end
  endtask

  task automatic test_threshold();
    int t0, fd, first, last;
    enable = 1'b1;
    ffi.out_ready = 1'b1;
    push_words(FL - 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (s_rd !== 1'b0 || s_busy !== 1'b0) begin
        n_err++;
        $display("FAIL below_thr rd=%b busy=%b required=0 0",
                 s_rd, s_busy);
      end
    end
    push_words(1);
    t0 = -1; fd = -1; first = -1; last = -1;
    npops = 0; ntx = 0;
    for (int c = 0; c < 120 && fd < 0; c++) begin
      tick();
      if (s_xfer) begin
        exp_w = 'x;
        if (sb.size() > 0) exp_w = sb.pop_front();
        n_vec++;
        if (s_obs !== exp_w) begin
          n_err++;
          $display("FAIL sb_word cyc=%0d actual=%h required=%h",
                   cyc, s_obs, exp_w);
        end
      end
      if (s_busy && t0 < 0) t0 = cyc;
      if (s_rd) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (s_fd) fd = cyc;
    end
    n_vec++;
    if (fd < 0 || fd - t0 != FL + 3) begin
      n_err++;
      $display("FAIL frame_latency actual=%0d required=%0d",
               fd - t0, FL + 3);
    end
    n_vec++;
    if (npops != FL || last - first != FL - 1 || first != t0) begin
      n_err++;
      $display("FAIL pop_burst pops=%0d span=%0d required=%0d %0d",
               npops, last - first + 1, FL, FL);
    end
    n_vec++;
    if (ntx != FL || sb.size() != 0) begin
      n_err++;
      $display("FAIL words_out actual=%0d required=%0d", ntx, FL);
    end
  endtask

  task automatic test_backpressure();
    int fd;
    logic prev_stall;
    logic [33:0] prev_obs;
    fd = -1; npops = 0; ntx = 0;
    prev_stall = 1'b0; prev_obs = '0;
    push_words(FL);
    for (int c = 0; c < 400 && fd < 0; c++) begin
      ffi.out_ready = (c % 2) == 0;
      tick();
      if (s_xfer) begin
        exp_w = 'x;
        if (sb.size() > 0) exp_w = sb.pop_front();
        n_vec++;
        if (s_obs !== exp_w) begin
          n_err++;
          $display("FAIL sb_word cyc=%0d actual=%h required=%h",
                   cyc, s_obs, exp_w);
        end
      end
      n_vec++;
      if (npops - ntx > 2) begin
        n_err++;
        $display("FAIL in_flight actual=%0d required<=2",
                 npops - ntx);
      end
      if (prev_stall && s_valid) begin
        n_vec++;
        if (s_obs !== prev_obs) begin
          n_err++;
          $display("FAIL stall_hold actual=%h required=%h",
                   s_obs, prev_obs);
        end
      end
      prev_stall = s_valid & ~s_xfer;
      prev_obs   = s_obs;
      if (s_fd) fd = cyc;
    end
    ffi.out_ready = 1'b1;
    n_vec++;
    if (fd < 0 || ntx != FL) begin
      n_err++;
      $display("FAIL bp_frame words=%0d done=%0d required=%0d 1",
               ntx, fd >= 0, FL);
    end
  endtask

  task automatic test_back_to_back();
    int nfd, ne;
    int fds [2];
    int ent [2];
    logic pb;
    nfd = 0; ne = 0; pb = 1'b0; ntx = 0;
    fds = '{default: 0};
    ent = '{default: 0};
    push_words(2 * FL);
    for (int c = 0; c < 300 && nfd < 2; c++) begin
      tick();
      if (s_xfer) begin
        exp_w = 'x;
        if (sb.size() > 0) exp_w = sb.pop_front();
        n_vec++;
        if (s_obs !== exp_w) begin
          n_err++;
          $display("FAIL sb_word cyc=%0d actual=%h required=%h",
                   cyc, s_obs, exp_w);
        end
      end
      if (s_busy && !pb && ne < 2) ent[ne++] = cyc;
      pb = s_busy;
      if (s_fd && nfd < 2) fds[nfd++] = cyc;
    end
    n_vec++;
    if (nfd != 2 || ne != 2) begin
      n_err++;
      $display("FAIL b2b_count done=%0d bursts=%0d required=2 2",
               nfd, ne);
    end
    n_vec++;
    if (ent[1] - fds[0] != 2) begin
      n_err++;
      $display("FAIL b2b_gap actual=%0d required=2",
               ent[1] - fds[0]);
    end
    n_vec++;
    if (ntx != 2 * FL) begin
      n_err++;
      $display("FAIL b2b_words actual=%0d required=%0d",
               ntx, 2 * FL);
    end
  endtask

  task automatic test_srst_mid();
    int fd;
    logic first_sof;
    logic got_first;
    ntx = 0;
    push_words(FL);
    for (int c = 0; c < 100 && ntx < 40; c++) begin
      tick();
      if (s_xfer) begin
        exp_w = 'x;
        if (sb.size() > 0) exp_w = sb.pop_front();
        n_vec++;
        if (s_obs !== exp_w) begin
          n_err++;
          $display("FAIL sb_word cyc=%0d actual=%h required=%h",
                   cyc, s_obs, exp_w);
        end
      end
    end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    flush();
    tick();
    n_vec++;
    if ({s_valid, s_busy, s_rd} !== 3'b000) begin
      n_err++;
      $display("FAIL srst_mid valid=%b busy=%b rd=%b required=000",
               s_valid, s_busy, s_rd);
    end
    push_words(FL);
    fd = -1; ntx = 0; got_first = 1'b0; first_sof = 1'b0;
    for (int c = 0; c < 150 && fd < 0; c++) begin
      tick();
      if (s_xfer) begin
        if (!got_first) first_sof = s_obs[33];
        got_first = 1'b1;
        exp_w = 'x;
        if (sb.size() > 0) exp_w = sb.pop_front();
        n_vec++;
        if (s_obs !== exp_w) begin
          n_err++;
          $display("FAIL sb_word cyc=%0d actual=%h required=%h",
                   cyc, s_obs, exp_w);
        end
      end
      if (s_fd) fd = cyc;
    end
    n_vec++;
    if (fd < 0 || ntx != FL || first_sof !== 1'b1) begin
      n_err++;
      $display("FAIL srst_refill words=%0d sof0=%b required=%0d 1",
               ntx, first_sof, FL);
    end
  endtask

  task automatic test_full_enable();
    int fd;
    fd = -1; ntx = 0;
    full_mode = 1'b1;
    enable = 1'b1;
    push_words(FL + 10);
    for (int c = 0; c < 200 && fd < 0; c++) begin
      tick();
      if (s_xfer) begin
        exp_w = 'x;
        if (sb.size() > 0) exp_w = sb.pop_front();
        n_vec++;
        if (s_obs !== exp_w) begin
          n_err++;
          $display("FAIL sb_word cyc=%0d actual=%h required=%h",
                   cyc, s_obs, exp_w);
        end
      end
      if (ntx >= 20) enable = 1'b0;
      if (s_fd) fd = cyc;
    end
    n_vec++;
    if (fd < 0 || ntx != FL) begin
      n_err++;
      $display("FAIL full_frame words=%0d done=%0d required=%0d 1",
               ntx, fd >= 0, FL);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++;
      if (s_busy !== 1'b0) begin
        n_err++;
        $display("FAIL no_restart actual=%b required=0", s_busy);
      end
    end
    full_mode = 1'b0;
    flush();
    enable = 1'b1;
  endtask

  task automatic test_underrun();
    int fd;
    fd = -1; npops = 0; ntx = 0;
    push_words(FL);
    for (int c = 0; c < 50 && npops < 10; c++) begin
      tick();
      if (s_xfer) begin
        exp_w = 'x;
        if (sb.size() > 0) exp_w = sb.pop_front();
        n_vec++;
        if (s_obs !== exp_w) begin
          n_err++;
          $display("FAIL sb_word cyc=%0d actual=%h required=%h",
                   cyc, s_obs, exp_w);
        end
      end
    end
    force_empty = 1'b1;
    fifo_upd();
    for (int h = 0; h < 5; h++) begin
      err_clr = (h == 3);
      tick();
      if (s_xfer) begin
        exp_w = 'x;
        if (sb.size() > 0) exp_w = sb.pop_front();
        n_vec++;
        if (s_obs !== exp_w) begin
          n_err++;
          $display("FAIL sb_word cyc=%0d actual=%h required=%h",
                   cyc, s_obs, exp_w);
        end
      end
      n_vec++;
      if (s_rd !== 1'b0) begin
        n_err++;
        $display("FAIL empty_gate h=%0d actual=%b required=0",
                 h, s_rd);
      end
      if (h == 1 || h == 4) begin
        n_vec++;
        if (s_err !== EXP_UR) begin
          n_err++;
          $display("FAIL underrun_set h=%0d actual=%b required=%b",
                   h, s_err, EXP_UR);
        end
      end
    end
    err_clr = 1'b0;
    n_vec++;
    if (npops != 10) begin
      n_err++;
      $display("FAIL pops_at_stall actual=%0d required=10", npops);
    end
    force_empty = 1'b0;
    err_clr = 1'b1;
    fifo_upd();
    tick();
    err_clr = 1'b0;
    for (int c = 0; c < 150 && fd < 0; c++) begin
      tick();
      if (c == 0) begin
        n_vec++;
        if (s_err !== 1'b0) begin
          n_err++;
          $display("FAIL underrun_clr actual=%b required=0", s_err);
        end
      end
      if (s_xfer) begin
        exp_w = 'x;
        if (sb.size() > 0) exp_w = sb.pop_front();
        n_vec++;
        if (s_obs !== exp_w) begin
          n_err++;
          $display("FAIL sb_word cyc=%0d actual=%h required=%h",
                   cyc, s_obs, exp_w);
        end
      end
      if (s_fd) fd = cyc;
    end
    n_vec++;
    if (fd < 0 || ntx != FL) begin
      n_err++;
      $display("FAIL ur_frame words=%0d done=%0d required=%0d 1",
               ntx, fd >= 0, FL);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    npops = 0; ntx = 0; pushcnt = 0;
    test_reset();
    test_threshold();
    test_backpressure();
    test_back_to_back();
    test_srst_mid();
    test_full_enable();
    test_underrun();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_fetch_ctrl.md
Name: frame_fetch_ctrl

Overview:
- Read-side sequencer for async_fifo: waits until one full speech frame (FRAME_LEN words) is buffered, then drains exactly that frame into the G729 encoder front end over a valid/ready stream.
- Sits in the portb (read) clock domain, between the FIFO read port and the encoder input.
- Handles the 1-cycle RAM read latency and downstream backpressure, and marks frame start and end.

Parameters:
- RAM_ADDR_WIDTH, 12, width of the FIFO count.
- RAM_DATA_WIDTH, 32, data word width.
- FRAME_LEN, 80, words per frame. Legal range 2 .. 2**RAM_ADDR_WIDTH-1.

Ports:
- clk  in  1  clock, same clock as the FIFO portb_clk
- srst  in  1  synchronous reset, active-high
- enable  in  1  permits a new frame to start
- fifo_rd_en  out  1  pop strobe to FIFO portb_rd_en
- fifo_rd_data  in  RAM_DATA_WIDTH  FIFO portb_rd_data; valid 1 cycle after pop
- fifo_empty  in  1  FIFO portb_fifo_empty
- fifo_full  in  1  FIFO portb_fifo_full
- fifo_count  in  RAM_ADDR_WIDTH  FIFO portb_fifo_count
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_data  out  RAM_DATA_WIDTH  output word
- out_sof  out  1  qualifies first word of a frame
- out_eof  out  1  qualifies last word of a frame
- busy  out  1  high when FSM is not IDLE
- frame_done  out  1  one-cycle pulse after the last word is accepted
- underrun_err  out  1  sticky error; see Optional Feature
- err_clr  in  1  clears underrun_err

Behaviour:
- Interface decision: one clock (clk). Reset srst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: all outputs 0, FSM in IDLE, all counters 0, output buffer empty.
- Frame available (frame_avail): fifo_full = 1, or fifo_count >= FRAME_LEN. The fifo_full term is needed because the FIFO count saturates when full.
- Output buffer: 2-entry, first-in first-out.
- Credit rule: fifo_rd_en may assert only when (reads in flight + buffered words) < 2. This guarantees no popped word is ever dropped under backpressure.
- Additional fifo_rd_en condition: fifo_empty = 0. This guard is required because the FIFO does not protect against reads when empty.
- Read latency: a pop in cycle N writes fifo_rd_data into the buffer at the end of cycle N+1.
- out_valid is high whenever the buffer is non-empty; out_data is the buffer head.
- A word transfers when out_valid & out_ready. out_data, out_sof and out_eof are held stable while out_valid & ~out_ready.
- rd_issued and wr_sent counters: width clog2(FRAME_LEN+1).
- out_sof = 1 when the head word is word 0 of the frame; out_eof = 1 when it is word FRAME_LEN-1.
- FSM state IDLE:
  - Go to BURST when enable & frame_avail.
  - Entering BURST clears rd_issued and wr_sent.
- FSM state BURST:
  - Pop whenever the credit rule and fifo_empty = 0 both allow; rd_issued increments on each pop.
  - Go to DRAIN on the cycle the FRAME_LEN-th pop issues.
- FSM state DRAIN:
  - No pops.
  - Go to DONE when wr_sent reaches FRAME_LEN.
- FSM state DONE:
  - frame_done = 1 for this single cycle.
  - Go to IDLE.
- Minimum gap between frames is 2 cycles (DONE, IDLE). Back-to-back frames are allowed if frame_avail is already true in IDLE.
- enable deasserted mid-frame: the current frame completes normally; no new frame starts.
- srst mid-frame: returns to the reset state on the next edge. In-flight and buffered words are discarded; the FIFO entries already popped are lost (accepted behaviour).
- Full-throughput case (out_ready held 1): one pop per cycle. Frame latency = FRAME_LEN+3 cycles from entering BURST to frame_done.

Optional Feature:
- Macro: FRAME_FETCH_UNDERRUN_EN.
- When defined:
  - underrun_err sets when the FSM is in BURST with rd_issued < FRAME_LEN and fifo_empty = 1 (should never happen given frame_avail).
  - underrun_err stays set until err_clr or srst.
  - If err_clr and the set condition occur together, set wins.
- When not defined: underrun_err tied 0 and err_clr ignored. Pop gating on fifo_empty stays active in both cases.

Test Plan:
- Reset then fill FIFO to fifo_count = 79, out_ready = 1 -> no fifo_rd_en, busy = 0. Push one more word (count = 80) -> BURST, 80 consecutive pops, 80 words out with sof on word 0 and eof on word 79, frame_done 83 cycles after BURST entry.
- out_ready toggled 1/0 every cycle with FRAME_LEN = 80 -> never more than 2 words in flight or buffered, words exit in order, data matches the write sequence, out_data held stable while stalled.
- Fill FIFO to 160 words -> two back-to-back frames; second BURST starts 2 cycles after the first DONE; 2 frame_done pulses.
- srst asserted at word 40 of a frame -> next cycle out_valid = 0 and busy = 0. After refill to 80 words, a new frame starts with sof on word 0.
- FIFO full (fifo_count saturated, fifo_full = 1), enable = 1 -> frame starts. With enable dropped mid-frame -> frame finishes and no new BURST begins.
- FRAME_FETCH_UNDERRUN_EN defined, fifo_empty forced to 1 at rd_issued = 10 -> pops stop and underrun_err = 1. Pulse err_clr with fifo_empty = 0 -> underrun_err clears and the frame completes.
